// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and parameter defaults.
package mul_arb_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned STATE_WIDTH    = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping; purely combinational.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant_c,
  output logic [ID_WIDTH-1:0] grant_id_c,
  output logic                any_c
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    any_c      = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((32'(ptr) + k) % NUM_REQ);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_id_c   = idx;
        grant_c[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one handshaked multi-cycle multiplier among NUM_REQ requesters, one op in flight,
// round-robin grants, product returned to the issuing requester with its id.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RES_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_2,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id,
  output logic [RES_WIDTH-1:0]            resp_data,
  output logic                            busy,
  output logic                            mul_wr_en,
  output logic [DATA_WIDTH-1:0]           mul_wr_data_1,
  output logic [DATA_WIDTH-1:0]           mul_wr_data_2,
  input  logic                            mul_wr_ready,
  output logic                            mul_rd_en,
  input  logic                            mul_rd_ready,
  input  logic                            mul_rd_val,
  input  logic [RES_WIDTH-1:0]            mul_rd_data
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, id_q;

  logic [NUM_REQ-1:0]    grant_c;
  logic [ID_WIDTH-1:0]   grant_id_c;
  logic                  any_c;
  logic                  take_c, done_c;
  logic [ID_WIDTH-1:0]   ptr_next_c;
  logic [NUM_REQ-1:0]    id_hot_c;
  logic [DATA_WIDTH-1:0] sel_a_c, sel_b_c;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .ptr        (ptr_q),
    .req        (req_valid),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c),
    .any_c      (any_c)
  );

  // Operand mux for the granted requester
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c[k]) begin
        sel_a_c = sel_a_c | req_data_1[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b_c = sel_b_c | req_data_2[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and event decode
  always_comb begin
    state_d    = state_q;
    take_c     = 1'b0;
    done_c     = 1'b0;
    ptr_next_c = (32'(grant_id_c) == NUM_REQ - 1) ? '0 : grant_id_c + ID_WIDTH'(1);
    id_hot_c   = NUM_REQ'(1) << id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          take_c  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: if (mul_wr_ready) state_d = ST_WAIT;
      ST_WAIT:  if (mul_rd_ready) state_d = ST_READ;
      ST_READ:  state_d = ST_RESP;
      ST_RESP: begin
        if (mul_rd_val) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latches and registered outputs; enables track the state they decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_id       <= '0;
      resp_data     <= '0;
      busy          <= 1'b0;
      mul_wr_en     <= 1'b0;
      mul_rd_en     <= 1'b0;
      mul_wr_data_1 <= '0;
      mul_wr_data_2 <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != ST_IDLE);
      mul_wr_en  <= (state_d == ST_ISSUE);
      mul_rd_en  <= (state_d == ST_READ);
      req_ready  <= take_c ? grant_c : '0;
      resp_valid <= done_c ? id_hot_c : '0;
      if (take_c) begin
        id_q          <= grant_id_c;
        ptr_q         <= ptr_next_c;
        mul_wr_data_1 <= sel_a_c;
        mul_wr_data_2 <= sel_b_c;
      end
      if (done_c) begin
        resp_id   <= id_q;
        resp_data <= mul_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural 4-cycle multiplier on the master port.
module tb_mul_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data_1 = '0;
  logic [NR*DW-1:0]  req_data_2 = '0;
  logic [NR-1:0]     req_ready, resp_valid;
  logic [1:0]        resp_id;
  logic [RW-1:0]     resp_data;
  logic              busy, mul_wr_en, mul_rd_en, mul_wr_ready;
  logic [DW-1:0]     mul_wr_data_1, mul_wr_data_2;
  logic              mul_rd_ready, mul_rd_val;
  logic [RW-1:0]     mul_rd_data;

  mul_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .RES_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data_1(req_data_1),
    .req_data_2(req_data_2), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy), .mul_wr_en(mul_wr_en),
    .mul_wr_data_1(mul_wr_data_1), .mul_wr_data_2(mul_wr_data_2),
    .mul_wr_ready(mul_wr_ready), .mul_rd_en(mul_rd_en), .mul_rd_ready(mul_rd_ready),
    .mul_rd_val(mul_rd_val), .mul_rd_data(mul_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: accepts on wr_en&&wr_ready, computes 4 cycles, read on rd_en
  logic        m_idle;
  int          m_cnt, wr_run, last_run, m_acc;
  int          stall_load = 0;
  logic [RW-1:0] m_prod;

  assign mul_wr_ready = m_idle && (wr_run >= stall_load);

  always @(posedge clk) begin
    if (reset) begin
      m_idle <= 1'b1; m_cnt <= 0; mul_rd_ready <= 1'b0; mul_rd_val <= 1'b0;
      mul_rd_data <= '0; m_prod <= '0; wr_run <= 0;
    end else begin
      wr_run <= mul_wr_en ? wr_run + 1 : 0;
      if (mul_wr_en && mul_wr_ready) begin
        m_prod <= RW'(mul_wr_data_1) * RW'(mul_wr_data_2);
        m_idle <= 1'b0;
        m_cnt  <= 4;
        m_acc  <= m_acc + 1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) mul_rd_ready <= 1'b1;
      end
      if (mul_rd_en) begin
        mul_rd_val   <= 1'b1;
        mul_rd_data  <= m_prod;
        mul_rd_ready <= 1'b0;
        m_idle       <= 1'b1;
      end
    end
    if (mul_wr_en) last_run <= wr_run + 1;
  end

  initial begin m_acc = 0; last_run = 0; end

  // Requesters: hold valid until their req_ready pulse, re-assert while ops remain
  int            pend [NR];
  logic [DW-1:0] opa  [NR];
  logic [DW-1:0] opb  [NR];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && pend[i] > 0) pend[i] = pend[i] - 1;
      req_valid[i] = (pend[i] > 0);
      req_data_1[i*DW +: DW] = opa[i];
      req_data_2[i*DW +: DW] = opb[i];
    end
  end

  // Scoreboard
  typedef struct { int id; logic [RW-1:0] data; } exp_t;
  int   gq [$];
  exp_t rq [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(string nm, logic [RW-1:0] got, logic [RW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: pops the expected grant/response whenever the DUT pulses one
  always @(negedge clk) begin
    if (!reset) begin
      if (|req_ready) begin
        if (gq.size() == 0) chk("unexpected_grant", RW'(req_ready), '0);
        else begin
          int g;
          g = gq.pop_front();
          chk("grant", RW'(req_ready), RW'(NR'(1) << g));
        end
      end
      if (|resp_valid) begin
        if (rq.size() == 0) chk("unexpected_resp", RW'(resp_valid), '0);
        else begin
          exp_t e;
          e = rq.pop_front();
          chk("resp_valid", RW'(resp_valid), RW'(NR'(1) << e.id));
          chk("resp_id", RW'(resp_id), RW'(e.id));
          chk("resp_data", resp_data, e.data);
        end
      end
    end
  end

  task automatic add_req(int i, logic [DW-1:0] a, logic [DW-1:0] b, int n);
    opa[i] = a; opb[i] = b; pend[i] = pend[i] + n;
  endtask

  task automatic push(int id, logic [RW-1:0] d);
    gq.push_back(id);
    rq.push_back('{id, d});
  endtask

  task automatic wait_idle(string nm, int budget);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (gq.size() == 0) && (rq.size() == 0) && !busy &&
           (pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0) && (pend[3] == 0);
    end
    chk(nm, RW'(ok), RW'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    gq.delete(); rq.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_rdy"},  RW'(req_ready), '0);
    chk({nm, "_rv"},   RW'(resp_valid), '0);
    chk({nm, "_rid"},  RW'(resp_id), '0);
    chk({nm, "_rdat"}, resp_data, '0);
    chk({nm, "_ctl"},  RW'({busy, mul_wr_en, mul_rd_en}), '0);
    chk({nm, "_wd"},   RW'({mul_wr_data_1, mul_wr_data_2}), '0);
  endtask

  initial begin
    int acc0;
    logic seen;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; opa[i] = '0; opb[i] = '0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Single requester 0: 3*5
    add_req(0, 32'd3, 32'd5, 1); push(0, 64'd15);
    wait_idle("t1_done", 60);

    // All four at once from ptr=0
    do_reset();
    add_req(0, 32'd1, 32'd10, 1); add_req(1, 32'd2, 32'd10, 1);
    add_req(2, 32'd3, 32'd10, 1); add_req(3, 32'd4, 32'd10, 1);
    push(0, 64'd10); push(1, 64'd20); push(2, 64'd30); push(3, 64'd40);
    wait_idle("t2_done", 200);

    // req0 and req2 held for 6 ops: alternate 0,2,...
    do_reset();
    add_req(0, 32'd4, 32'd5, 3); add_req(2, 32'd6, 32'd7, 3);
    for (int k = 0; k < 3; k++) begin push(0, 64'd20); push(2, 64'd42); end
    wait_idle("t3_done", 300);

    // Max operands
    add_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); push(0, 64'hFFFF_FFFE_0000_0001);
    wait_idle("t4_done", 60);

    // Multiplier refuses writes for 5 cycles: wr_en held, one accept
    stall_load = 5;
    acc0 = m_acc;
    add_req(2, 32'd9, 32'd9, 1); push(2, 64'd81);
    wait_idle("t5_done", 80);
    chk("t5_wr_en_cycles", RW'(last_run), RW'(6));
    chk("t5_accepts", RW'(m_acc - acc0), RW'(1));
    stall_load = 0;

    // Reset while WAIT aborts the op
    add_req(1, 32'd2, 32'd2, 1); gq.push_back(1);
    seen = 1'b0;
    for (int c = 0; c < 40 && !(seen && !mul_wr_en); c++) begin
      @(negedge clk);
      if (mul_wr_en) seen = 1'b1;
    end
    chk("t6_in_wait", RW'({busy, mul_wr_en, mul_rd_en, mul_rd_ready}), RW'(4'b1000));
    reset = 1'b1;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    gq.delete(); rq.delete();
    @(negedge clk);
    chk_zero("t6_abort");
    reset = 1'b0;
    add_req(3, 32'd7, 32'd6, 1); push(3, 64'd42);
    wait_idle("t6_done", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
